expander_req_arbiter: RTL

Round-robin scheduler that shares the single request conduit of the `i2c_expander_sfp` GPIO expander between several client blocks (SFP LED blinker, TX_FAULT/LOS poller, RS0/RS1 rate configurator). It accepts level requests carrying an operation code and issues exactly one expander operation at a time. Each operation is a one-cycle `need_*` pulse, followed by a wait for the expander's `ready` rising edge and an optional relax gap. Each client gets a per-requester done/error pulse.

---
 rtl/expander_req_arbiter_if.sv | 28 ++
 rtl/expander_req_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/expander_req_arbiter_if.sv
// Request/handshake bundle between the SFP client blocks, the expander
// request arbiter and the i2c_expander_sfp request conduit.
interface expander_req_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  logic [NUM_REQ-1:0]   req_i;
  logic [2*NUM_REQ-1:0] req_op_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic [NUM_REQ-1:0]   done_o;
  logic [NUM_REQ-1:0]   err_o;
  logic                 busy_o;
  logic                 dev_ready_i;
  logic                 need_write_reg_o;
  logic                 need_read_reg_i;
  logic                 need_read_reg_o;

  modport master (
    output req_i, req_op_i, dev_ready_i,
    input  grant_o, done_o, err_o, busy_o,
    input  need_write_reg_o, need_read_reg_i, need_read_reg_o
  );

  modport slave (
    input  req_i, req_op_i, dev_ready_i,
    output grant_o, done_o, err_o, busy_o,
    output need_write_reg_o, need_read_reg_i, need_read_reg_o
  );
endinterface

// File: rtl/expander_req_arbiter.sv
// Round-robin scheduler issuing one i2c_expander_sfp operation at a time.
// EXP_ARB_RELAX_EN: when defined, a RELAX_CYCLES idle gap follows every operation.
module expander_req_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int RELAX_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                         clk_50,
  input  logic                         rst,
  expander_req_arbiter_if.slave        bus
);
  localparam int          PTR_W        = $clog2(NUM_REQ);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
`ifdef EXP_ARB_RELAX_EN
  localparam logic [31:0] RELAX_LAST   = 32'(RELAX_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    DONE      = 3'd3
`ifdef EXP_ARB_RELAX_EN
    , RELAX   = 3'd4
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               ready_prev_q;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               busy_q, busy_d;
  logic               need_wr_q, need_wr_d;
  logic               need_ri_q, need_ri_d;
  logic               need_ro_q, need_ro_d;

  logic               found_s;
  logic [PTR_W-1:0]   pick_s;
  logic [1:0]         pick_op_s;
  logic               ready_rise_s;

  assign ready_rise_s = bus.dev_ready_i & ~ready_prev_q;

  // Winner search: first asserted request at or above the pointer, wrapping.
  always_comb begin
    found_s   = 1'b0;
    pick_s    = '0;
    pick_op_s = 2'b00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && bus.req_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        found_s   = 1'b1;
        pick_s    = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        pick_op_s = bus.req_op_i[2*((int'(rr_ptr_q) + k) % NUM_REQ) +: 2];
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Next-state and next-output logic of the operation sequencer.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = '0;
    need_wr_d = 1'b0;
    need_ri_d = 1'b0;
    need_ro_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s && bus.dev_ready_i) begin
          state_d   = ISSUE;
          op_d      = pick_op_s;
          rr_ptr_d  = PTR_W'((int'(pick_s) + 1) % NUM_REQ);
          grant_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          need_wr_d = (pick_op_s == 2'b00);
          need_ri_d = (pick_op_s == 2'b01);
          need_ro_d = (pick_op_s == 2'b10);
        end else begin
          grant_d   = '0;
        end
      end
      ISSUE: begin
        cnt_d = 32'd0;
        // An invalid op never reaches the expander; report it straight away.
        if (op_q == 2'b11) begin
          state_d = DONE;
          done_d  = grant_q;
          err_d   = grant_q;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ready_rise_s) begin
          state_d = DONE;
          done_d  = grant_q;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = DONE;
          done_d  = grant_q;
          err_d   = grant_q;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
      DONE: begin
        grant_d = '0;
        cnt_d   = 32'd0;
`ifdef EXP_ARB_RELAX_EN
        state_d = RELAX;
`else
        state_d = IDLE;
`endif
      end
`ifdef EXP_ARB_RELAX_EN
      RELAX: begin
        if (cnt_q == RELAX_LAST) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = 32'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_q         <= 2'b00;
      cnt_q        <= 32'd0;
      ready_prev_q <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      need_wr_q    <= 1'b0;
      need_ri_q    <= 1'b0;
      need_ro_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      ready_prev_q <= bus.dev_ready_i;
      grant_q      <= grant_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      need_wr_q    <= need_wr_d;
      need_ri_q    <= need_ri_d;
      need_ro_q    <= need_ro_d;
    end
  end

  assign bus.grant_o          = grant_q;
  assign bus.done_o           = done_q;
  assign bus.err_o            = err_q;
  assign bus.busy_o           = busy_q;
  assign bus.need_write_reg_o = need_wr_q;
  assign bus.need_read_reg_i  = need_ri_q;
  assign bus.need_read_reg_o  = need_ro_q;
endmodule
